// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator and its capture counterpart.
package pwm_pkg;

    localparam int unsigned PwmDivTrig = 12;
    localparam int unsigned PwmCntW    = 10;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bundle from the capture block towards the SPI register file.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = pwm_pkg::PwmCntW
);

    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] period_o;
    logic             valid_o;
    logic             stuck_o;
    logic             level_o;

    modport master (
        output high_o,
        output period_o,
        output valid_o,
        output stuck_o,
        output level_o
    );

    modport slave (
        input high_o,
        input period_o,
        input valid_o,
        input stuck_o,
        input level_o
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin plus a one-clock delayed copy
// used to derive rising and falling edges of the synchronized level.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic in_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign in_s_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Input capture for one of eight PWM pins: measures high time and period in
// prescaler ticks and reports constant pins by timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned DIV_TRIG = PwmDivTrig,
    parameter int unsigned CNT_W    = PwmCntW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    pwm_in,
    input  logic [2:0]    sel,
    pwm_capture_if.master res
);

    localparam int unsigned    DivW   = (DIV_TRIG > 0) ? $clog2(DIV_TRIG + 1) : 1;
    localparam logic [DivW-1:0] DivTop = DivW'(DIV_TRIG);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic in_s, rise, fall, tick;

    logic [DivW-1:0]  div_q, div_d;
    logic [2:0]       sel_q, sel_d;
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] high_res_q, high_res_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_load;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pwm_in[sel]),
        .in_s_o (in_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        tick     = (div_q == DivTop);
        div_d    = tick ? '0 : div_q + 1'b1;
        sel_d    = sel;
        cnt_load = tick ? CNT_W'(1) : '0;

        state_d    = state_q;
        per_d      = (tick && per_q != CntMax) ? per_q + 1'b1 : per_q;
        high_d     = high_q;
        high_res_d = high_res_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        level_d    = level_q;

        if (tick && in_s && state_q != StIdle && high_q != CntMax) begin
            high_d = high_q + 1'b1;
        end

        if (!en || sel != sel_q) begin
            state_d = StIdle;
            per_d   = '0;
            high_d  = '0;
        end else if (rise) begin
            if (state_q == StLow) begin
                period_d   = per_q;
                high_res_d = high_q;
                stuck_d    = 1'b0;
                valid_d    = 1'b1;
            end
            // The tick coinciding with the rise opens the new period.
            state_d = StHigh;
            per_d   = cnt_load;
            high_d  = cnt_load;
        end else if (tick && per_q == CntMax) begin
            period_d   = '0;
            high_res_d = '0;
            stuck_d    = 1'b1;
            level_d    = in_s;
            valid_d    = 1'b1;
            state_d    = StIdle;
            per_d      = '0;
            high_d     = '0;
        end else if (fall && state_q == StHigh) begin
            state_d = StLow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            sel_q      <= '0;
            state_q    <= StIdle;
            per_q      <= '0;
            high_q     <= '0;
            high_res_q <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            sel_q      <= sel_d;
            state_q    <= state_d;
            per_q      <= per_d;
            high_q     <= high_d;
            high_res_q <= high_res_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            level_q    <= level_d;
        end
    end

    assign res.high_o   = high_res_q;
    assign res.period_o = period_q;
    assign res.valid_o  = valid_q;
    assign res.stuck_o  = stuck_q;
    assign res.level_o  = level_q;

endmodule
